// File: rtl/decode_queue.sv
// Instruction queue between fetch and decode with per-entry predecode flags and a HALT fence.
// Optional same-cycle empty-queue bypass is enabled by defining DECODE_QUEUE_BYPASS_EN.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_inst,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_inst,
    output logic [PC_W-1:0]            out_pc,
    output logic [6:0]                 out_cls,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Flag order {ldst, branch, jmp, rti, illegal, nop, halt}; decoded from opcode inst[15:11].
    function automatic logic [6:0] predecode(input logic [15:0] inst);
        logic [6:0] cls;
        cls = '0;
        casez (inst[15:11])
            5'b00000:                   cls[0] = 1'b1;
            5'b00001:                   cls[1] = 1'b1;
            5'b00010:                   cls[2] = 1'b1;
            5'b00011:                   cls[3] = 1'b1;
            5'b001??:                   cls[4] = 1'b1;
            5'b011??:                   cls[5] = 1'b1;
            5'b10000, 5'b10001, 5'b10011: cls[6] = 1'b1;
            default:                    cls    = '0;
        endcase
        return cls;
    endfunction

    logic [15:0]     inst_mem [DEPTH];
    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic [6:0]      cls_mem  [DEPTH];

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          halted_q, halted_d;

    logic [6:0] in_cls;
    logic       empty, full, bypass, push, pop, wr_en, rd_en;

    assign in_cls = predecode(in_inst);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    // Equal index bits with differing MSBs means the writer has lapped the reader.
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign in_ready = !rst && !flush && !halted_q && !full;
    assign push     = in_valid && in_ready;

`ifdef DECODE_QUEUE_BYPASS_EN
    assign bypass = empty && push;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !empty || bypass;
    assign pop       = out_valid && out_ready;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign wr_en     = push && !(bypass && out_ready);
    assign rd_en     = pop && !bypass;

    always_comb begin
        out_inst = '0;
        out_pc   = '0;
        out_cls  = '0;
        if (bypass) begin
            out_inst = in_inst;
            out_pc   = in_pc;
            out_cls  = in_cls;
        end else if (!empty) begin
            out_inst = inst_mem[rd_ptr_q[AW-1:0]];
            out_pc   = pc_mem[rd_ptr_q[AW-1:0]];
            out_cls  = cls_mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + CW'(wr_en);
        rd_ptr_d = rd_ptr_q + CW'(rd_en);
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        halted_d = halted_q || (push && in_cls[0]);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // NOTE: storage is left unreset; entries are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            inst_mem[wr_ptr_q[AW-1:0]] <= in_inst;
            pc_mem[wr_ptr_q[AW-1:0]]   <= in_pc;
            cls_mem[wr_ptr_q[AW-1:0]]  <= in_cls;
        end
    end

    assign count  = count_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH=4, PC_W=16).
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_inst;
    logic [15:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic [6:0]  out_cls;
    logic        flush;
    logic [2:0]  count;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(4), .PC_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_inst  (in_inst),
        .in_pc    (in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst (out_inst),
        .out_pc   (out_pc),
        .out_cls  (out_cls),
        .flush    (flush),
        .count    (count),
        .halted   (halted)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
        step();
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_checks++;
        if ({out_inst, out_pc, out_cls} !== 39'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h/%h/%h exp 0", out_inst, out_pc, out_cls);
        end
        n_checks++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b exp 0", halted); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_fill_drain();
        logic [15:0] vec [4] = '{16'h481F, 16'h8810, 16'h78FF, 16'h20FF};
        logic [6:0]  cls [4] = '{7'h00, 7'h40, 7'h20, 7'h10};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_inst = vec[i]; in_pc = 16'h0040 + 16'(i);
            #1;
            if (i == 0) begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_pre: got %b exp 0", out_valid); end
            end
            step();
            if (i == 0) begin
                n_checks++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_post: got %b exp 1", out_valid); end
            end
        end
        in_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d exp 4", count); end
        n_checks++;
        if (out_inst !== 16'h481F) begin n_fail++; $display("FAIL hold_stable: got %h exp 481F", out_inst); end
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 16'h0800;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b exp 0", in_ready); end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_inst !== vec[i] || out_pc !== 16'h0040 + 16'(i) || out_cls !== cls[i]) begin
                n_fail++;
                $display("FAIL drain_%0d: got v=%b %h/%h/%h exp 1 %h/%h/%h", i, out_valid, out_inst, out_pc, out_cls,
                         vec[i], 16'h0040 + 16'(i), cls[i]);
            end
            step();
        end
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_inst !== 16'h0) begin
            n_fail++; $display("FAIL drain_empty: got v=%b cnt=%0d inst=%h exp 0 0 0", out_valid, count, out_inst);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_halt();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 16'h1234; in_pc = 16'h0008;
        step();
        n_checks++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %b exp 0", halted); end
        in_inst = 16'h0000; in_pc = 16'h0010;
        step();
        in_inst = 16'h8810; in_pc = 16'h0018;
        #1;
        n_checks++;
        if (halted !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL halt_set: got halted=%b in_ready=%b exp 1 0", halted, in_ready);
        end
        step();
        step();
        n_checks++;
        if (count !== 3'd2) begin n_fail++; $display("FAIL halt_fenced: got %0d exp 2", count); end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_inst !== 16'h1234 || out_cls !== 7'h04) begin
            n_fail++; $display("FAIL halt_drain0: got %h/%h exp 1234/04", out_inst, out_cls);
        end
        step();
        n_checks++;
        if (out_inst !== 16'h0000 || out_pc !== 16'h0010 || out_cls !== 7'h01 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL halt_entry: got v=%b %h/%h/%h exp 1 0000/0010/01", out_valid, out_inst, out_pc, out_cls);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || halted !== 1'b1) begin
            n_fail++; $display("FAIL halt_hold: got v=%b halted=%b exp 0 1", out_valid, halted);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        n_checks++;
        if (halted !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL halt_flush: got halted=%b in_ready=%b exp 0 1", halted, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 16'h481F; in_pc = 16'h0100;
        step();
        in_inst = 16'h8810; in_pc = 16'h0102;
        step();
        n_checks++;
        if (count !== 3'd2) begin n_fail++; $display("FAIL flush_pre: got %0d exp 2", count); end
        flush = 1'b1; in_inst = 16'h0800; in_pc = 16'h0104; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b exp 0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear: got cnt=%0d v=%b halted=%b exp 0 0 0", count, out_valid, halted);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0 || out_inst === 16'h0800) begin
                n_fail++; $display("FAIL flush_ghost_%0d: got v=%b inst=%h exp 0", i, out_valid, out_inst);
            end
        end
        in_valid = 1'b1; in_inst = 16'h20FF; in_pc = 16'h0200; out_ready = 1'b0;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_inst !== 16'h20FF || out_pc !== 16'h0200 || out_cls !== 7'h10) begin
            n_fail++; $display("FAIL flush_refill: got %h/%h/%h exp 20FF/0200/10", out_inst, out_pc, out_cls);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [22];
        logic [6:0]  cls [22];
        for (int i = 0; i < 22; i++) begin
            case (i % 3)
                0:       begin seq[i] = 16'h10FF; cls[i] = 7'h04; end
                1:       begin seq[i] = 16'h18FF; cls[i] = 7'h08; end
                default: begin seq[i] = 16'hC000 | 16'(i); cls[i] = 7'h00; end
            endcase
        end
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_inst = seq[i]; in_pc = 16'h0300 + 16'(i);
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_inst = seq[c + 2]; in_pc = 16'h0300 + 16'(c + 2);
            #1;
            n_checks++;
            if (out_inst !== seq[c] || out_pc !== 16'h0300 + 16'(c) || out_cls !== cls[c] || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %h/%h/%h rdy=%b exp %h/%h/%h 1", c, out_inst, out_pc, out_cls, in_ready,
                         seq[c], 16'h0300 + 16'(c), cls[c]);
            end
            step();
            n_checks++;
            if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count_%0d: got %0d exp 2", c, count); end
        end
        in_valid = 1'b0;
        for (int c = 20; c < 22; c++) begin
            #1;
            n_checks++;
            if (out_inst !== seq[c] || out_pc !== 16'h0300 + 16'(c)) begin
                n_fail++; $display("FAIL b2b_tail_%0d: got %h/%h exp %h/%h", c, out_inst, out_pc, seq[c], 16'h0300 + 16'(c));
            end
            step();
        end
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d exp 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_inst = 16'h8800 + 16'(i); in_pc = 16'h0400 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd3) begin n_fail++; $display("FAIL rst_mid_pre: got %0d exp 3", count); end
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || out_inst !== 16'h0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: got cnt=%0d inst=%h v=%b exp 0 0000 0", count, out_inst, out_valid);
        end
    endtask

    task automatic test_empty_push();
        in_valid = 1'b1; in_inst = 16'h0800; in_pc = 16'h0500; out_ready = 1'b1;
        #1;
`ifdef DECODE_QUEUE_BYPASS_EN
        n_checks++;
        if (out_valid !== 1'b1 || out_cls !== 7'h02 || out_inst !== 16'h0800 || out_pc !== 16'h0500) begin
            n_fail++; $display("FAIL bypass_same_cycle: got v=%b %h/%h/%h exp 1 0800/0500/02", out_valid, out_inst, out_pc, out_cls);
        end
        step();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bypass_no_write: got cnt=%0d v=%b exp 0 0", count, out_valid);
        end
`else
        n_checks++;
        if (out_valid !== 1'b0 || out_cls !== 7'h00) begin
            n_fail++; $display("FAIL nobypass_same_cycle: got v=%b cls=%h exp 0 00", out_valid, out_cls);
        end
        step();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_cls !== 7'h02 || count !== 3'd1) begin
            n_fail++; $display("FAIL nobypass_next: got v=%b cls=%h cnt=%0d exp 1 02 1", out_valid, out_cls, count);
        end
        step();
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL nobypass_pop: got %0d exp 0", count); end
`endif
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_halt();
        test_flush();
        test_back_to_back();
        test_rst_mid();
        test_empty_push();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
